mdio_hst_cmd_engine: RTL and testbench

Parametrised successor to the MAC host-interface MDIO configurator: after MAC reset release, writes a programmable set of MAC configuration words over the host interface, then executes queued MDIO accesses from the PCIe side. Adds a command FIFO, read-data return, a ready timeout, overflow accounting and re-initialisation on MAC reset. Sits between tlp2mdio (commands in) and irq_gen (completion interrupt) on the 10G MAC host bus.

---
 rtl/mdio_hst_cmd_engine_pkg.sv | 70 +++++++
 rtl/mdio_hst_cmd_engine_fifo.sv | 51 +++++
 rtl/mdio_hst_cmd_engine.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_mdio_hst_cmd_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_hst_cmd_engine_pkg.sv
// mdio_cfg_pkg: shared definitions for the MDIO host command engine.
//   - FSM state encoding
//   - MAC configuration register addresses and host opcodes
//   - acc_data field layout (command word) and completion-word layout
package mdio_cfg_pkg;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_WAIT_MAC = 4'd1,
    ST_SETTLE   = 4'd2,
    ST_CFG      = 4'd3,
    ST_CFG_GAP  = 4'd4,
    ST_IDLE     = 4'd5,
    ST_ISSUE    = 4'd6,
    ST_REQ      = 4'd7,
    ST_WAIT_RDY = 4'd8,
    ST_DONE     = 4'd9
  } state_e;

  // MAC configuration registers written after MAC reset release
  localparam logic [9:0] CFG_ADDR_RX   = 10'h240;
  localparam logic [9:0] CFG_ADDR_TX   = 10'h280;
  localparam logic [9:0] CFG_ADDR_MGMT = 10'h340;
  localparam logic [1:0] CFG_LAST_IDX  = 2'd2;

  // Host opcodes
  localparam logic [1:0] OP_CFG_WR = 2'b01;
  localparam logic [1:0] OP_IDLE   = 2'b11;

  // acc_data layout: [31:28] ignored, [27:26] op, [25:16] addr, [15:0] data
  localparam int unsigned ACC_OP_LSB   = 26;
  localparam int unsigned ACC_ADDR_LSB = 16;
  localparam int unsigned ACC_DATA_LSB = 0;
  localparam int unsigned CMD_W        = 28;

  typedef struct packed {
    logic [1:0]  op;
    logic [9:0]  addr;
    logic [15:0] data;
  } cmd_t;

  // Completion word: {timeout, 3'b0, op, addr, data}
  typedef struct packed {
    logic        timeout;
    logic [2:0]  rsvd;
    logic [1:0]  op;
    logic [9:0]  addr;
    logic [15:0] data;
  } cmp_t;

  function automatic logic [9:0] cfg_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return CFG_ADDR_RX;
      2'd1:    return CFG_ADDR_TX;
      default: return CFG_ADDR_MGMT;
    endcase
  endfunction

  function automatic logic [31:0] pack_cmp(input logic tmo, input cmd_t cmd,
                                           input logic [15:0] data);
    cmp_t c;
    c.timeout = tmo;
    c.rsvd    = 3'b000;
    c.op      = cmd.op;
    c.addr    = cmd.addr;
    c.data    = data;
    return c;
  endfunction

endpackage

// File: rtl/mdio_hst_cmd_engine_fifo.sv
// mdio_cmd_fifo: synchronous command FIFO.
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i/wdata_i write strobe and data (ignored while full, even with a pop)
//   pop_i/rdata_o  read strobe; rdata_o shows the head entry (first-word fall-through)
//   flush_i        empties the queue; wins over push and pop
//   full_o/empty_o status
module mdio_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 28
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to distinguish full from empty
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mdio_hst_cmd_engine.sv
// mdio_hst_cmd_engine: after MAC reset release, writes RX/TX/MGMT configuration
// words over the MAC host interface, then executes queued MDIO accesses.
//   host_clk, host_reset           clock, synchronous active-high reset
//   mac_rst                        asynchronous MAC reset (synchronised here)
//   host_opcode/addr/wr_data/...   MAC host bus (miim_sel 0 = config, 1 = MDIO)
//   host_req, host_miim_rdy        MDIO request strobe / engine ready
//   acc_data, acc_en               command push from the PCIe side
//   fifo_full, ovf_cnt             queue status, saturating drop counter
//   cmp_valid, cmp_data, send_irq  one-cycle completion {timeout,3'b0,op,addr,data}
//   init_done                      configuration sequence complete
module mdio_hst_cmd_engine
  import mdio_cfg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned RDY_TIMEOUT = 1024,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter logic [31:0] RX_CFG      = 32'h1C00_0000,
  parameter logic [31:0] TX_CFG      = 32'h1100_0000,
  parameter logic [31:0] MGMT_CFG    = 32'h0000_0029
) (
  input  logic        host_clk,
  input  logic        host_reset,
  input  logic        mac_rst,
  output logic [1:0]  host_opcode,
  output logic [9:0]  host_addr,
  output logic [31:0] host_wr_data,
  input  logic [31:0] host_rd_data,
  output logic        host_miim_sel,
  output logic        host_req,
  input  logic        host_miim_rdy,
  input  logic [31:0] acc_data,
  input  logic        acc_en,
  output logic        fifo_full,
  output logic [7:0]  ovf_cnt,
  output logic        cmp_valid,
  output logic [31:0] cmp_data,
  output logic        init_done,
  output logic        send_irq
);

  // SETTLE_CYC is expected to be at least 1
  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TW = $clog2(RDY_TIMEOUT);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(RDY_TIMEOUT - 1);

  function automatic logic [31:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return RX_CFG;
      2'd1:    return TX_CFG;
      default: return MGMT_CFG;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      mac_sync_q;
  logic            mac_rst_s;
  logic [SW-1:0]   settle_q, settle_d;
  logic [1:0]      idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  cmd_t            cmd_q, cmd_d;
  logic [1:0]      opcode_q, opcode_d;
  logic [9:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            sel_q, sel_d;
  logic            req_q, req_d;
  logic            cmp_valid_q, cmp_valid_d;
  logic [31:0]     cmp_data_q, cmp_data_d;
  logic            init_q, init_d;
  logic [7:0]      ovf_q;

  logic             fifo_pop, fifo_flush, fifo_full_w, fifo_empty_w;
  logic [CMD_W-1:0] fifo_rdata;
  cmd_t             head_cmd;
  logic             unused_bits;

  assign unused_bits = ^{acc_data[31:CMD_W], host_rd_data[31:16]};
  assign head_cmd    = cmd_t'(fifo_rdata);
  assign mac_rst_s   = mac_sync_q[1];

  mdio_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i   (host_clk),
    .rst_i   (host_reset),
    .push_i  (acc_en),
    .wdata_i (acc_data[CMD_W-1:0]),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty_w)
  );

  always_ff @(posedge host_clk) begin
    if (host_reset) mac_sync_q <= '1;
    else            mac_sync_q <= {mac_sync_q[0], mac_rst};
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    cmd_d       = cmd_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    req_d       = req_q;
    cmp_valid_d = 1'b0;
    cmp_data_d  = cmp_data_q;
    init_d      = init_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    case (state_q)
      ST_RST: begin
        opcode_d = OP_IDLE;
        addr_d   = '0;
        wdata_d  = '0;
        sel_d    = 1'b0;
        req_d    = 1'b0;
        settle_d = '0;
        idx_d    = '0;
        tmo_d    = '0;
        init_d   = 1'b0;
        state_d  = ST_WAIT_MAC;
      end
      ST_WAIT_MAC: begin
        settle_d = '0;
        if (!mac_rst_s) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          idx_d    = '0;
          opcode_d = OP_CFG_WR;
          addr_d   = cfg_addr(2'd0);
          wdata_d  = cfg_word(2'd0);
          state_d  = ST_CFG;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_CFG: begin
        opcode_d = OP_IDLE;
        addr_d   = '0;
        wdata_d  = '0;
        state_d  = ST_CFG_GAP;
      end
      ST_CFG_GAP: begin
        if (idx_q == CFG_LAST_IDX) begin
          init_d  = 1'b1;
          sel_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d    = idx_q + 2'd1;
          opcode_d = OP_CFG_WR;
          addr_d   = cfg_addr(idx_q + 2'd1);
          wdata_d  = cfg_word(idx_q + 2'd1);
          state_d  = ST_CFG;
        end
      end
      ST_IDLE: begin
        sel_d = 1'b1;
        if (!fifo_empty_w) begin
          fifo_pop = 1'b1;
          cmd_d    = head_cmd;
          tmo_d    = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The ready budget covers the wait before the request as well
        if (host_miim_rdy) begin
          opcode_d = cmd_q.op;
          addr_d   = cmd_q.addr;
          wdata_d  = {16'h0000, cmd_q.data};
          req_d    = 1'b1;
          state_d  = ST_REQ;
        end else if (tmo_q == TMO_LAST) begin
          cmp_valid_d = 1'b1;
          cmp_data_d  = pack_cmp(1'b1, cmd_q, 16'h0000);
          state_d     = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_REQ: begin
        req_d   = 1'b0;
        state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (host_miim_rdy) begin
          cmp_valid_d = 1'b1;
          cmp_data_d  = pack_cmp(1'b0, cmd_q,
                                 cmd_q.op[1] ? host_rd_data[15:0] : cmd_q.data);
          state_d     = ST_DONE;
        end else if (tmo_q == TMO_LAST) begin
          cmp_valid_d = 1'b1;
          cmp_data_d  = pack_cmp(1'b1, cmd_q, 16'h0000);
          state_d     = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    // MAC reset past WAIT_MAC discards everything in flight and restarts init
    if (mac_rst_s && (state_q != ST_RST) && (state_q != ST_WAIT_MAC)) begin
      state_d     = ST_WAIT_MAC;
      fifo_flush  = 1'b1;
      fifo_pop    = 1'b0;
      init_d      = 1'b0;
      req_d       = 1'b0;
      cmp_valid_d = 1'b0;
      opcode_d    = OP_IDLE;
      addr_d      = '0;
      wdata_d     = '0;
      sel_d       = 1'b0;
    end
  end

  always_ff @(posedge host_clk) begin
    if (host_reset) begin
      state_q     <= ST_RST;
      settle_q    <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      cmd_q       <= '0;
      opcode_q    <= OP_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= 1'b0;
      req_q       <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_data_q  <= '0;
      init_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      cmd_q       <= cmd_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      req_q       <= req_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_data_q  <= cmp_data_d;
      init_q      <= init_d;
    end
  end

  // Drops are counted whenever a push meets a full queue
  always_ff @(posedge host_clk) begin
    if (host_reset)                                   ovf_q <= '0;
    else if (acc_en && fifo_full_w && (ovf_q != '1)) ovf_q <= ovf_q + 8'd1;
  end

  assign host_opcode   = opcode_q;
  assign host_addr     = addr_q;
  assign host_wr_data  = wdata_q;
  assign host_miim_sel = sel_q;
  assign host_req      = req_q;
  assign cmp_valid     = cmp_valid_q;
  assign send_irq      = cmp_valid_q;
  assign cmp_data      = cmp_data_q;
  assign init_done     = init_q;
  assign fifo_full     = fifo_full_w;
  assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_mdio_hst_cmd_engine.sv
module tb_mdio_hst_cmd_engine;

  localparam int unsigned TB_TMO = 20;

  logic        host_clk = 1'b0;
  logic        host_reset;
  logic        mac_rst;
  logic [1:0]  host_opcode;
  logic [9:0]  host_addr;
  logic [31:0] host_wr_data;
  logic [31:0] host_rd_data;
  logic        host_miim_sel;
  logic        host_req;
  logic        host_miim_rdy;
  logic [31:0] acc_data;
  logic        acc_en;
  logic        fifo_full;
  logic [7:0]  ovf_cnt;
  logic        cmp_valid;
  logic [31:0] cmp_data;
  logic        init_done;
  logic        send_irq;

  mdio_hst_cmd_engine #(
    .FIFO_DEPTH  (4),
    .RDY_TIMEOUT (TB_TMO),
    .SETTLE_CYC  (4),
    .RX_CFG      (32'h1C00_0000),
    .TX_CFG      (32'h1100_0000),
    .MGMT_CFG    (32'h0000_0029)
  ) dut (
    .host_clk      (host_clk),
    .host_reset    (host_reset),
    .mac_rst       (mac_rst),
    .host_opcode   (host_opcode),
    .host_addr     (host_addr),
    .host_wr_data  (host_wr_data),
    .host_rd_data  (host_rd_data),
    .host_miim_sel (host_miim_sel),
    .host_req      (host_req),
    .host_miim_rdy (host_miim_rdy),
    .acc_data      (acc_data),
    .acc_en        (acc_en),
    .fifo_full     (fifo_full),
    .ovf_cnt       (ovf_cnt),
    .cmp_valid     (cmp_valid),
    .cmp_data      (cmp_data),
    .init_done     (init_done),
    .send_irq      (send_irq)
  );

  always #5 host_clk = ~host_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cmp   = 0;

  logic [31:0] cmp_exp[$];
  logic [41:0] cfg_exp[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // MDIO engine model: busy for 3 cycles after each request, read data derived from addr
  int          busy = 0;
  bit          hang = 0;
  logic [9:0]  last_addr = '0;

  initial begin
    host_miim_rdy = 1'b1;
    host_rd_data  = '0;
    forever begin
      @(posedge host_clk);
      #1;
      if (host_req === 1'b1) begin
        busy      = 3;
        last_addr = host_addr;
      end else if (busy > 0 && !hang) begin
        busy--;
      end
      host_rd_data  = (busy == 0) ? {16'hBEEF, 16'h122F + {6'h0, last_addr}} : 32'hFFFF_FFFF;
      host_miim_rdy = (busy == 0);
    end
  end

  // Monitor: config writes, request pulses and completions
  bit prev_cfg = 0;
  bit prev_req = 0;
  always @(negedge host_clk) begin
    if (!host_reset) begin
      if (host_opcode == 2'b01 && host_miim_sel == 1'b0) begin
        if (cfg_exp.size() == 0) check("cfg_unexpected", {host_addr, host_wr_data}, 64'h0);
        else check("cfg_write", {host_addr, host_wr_data}, cfg_exp.pop_front());
        check("cfg_gap", prev_cfg, 0);
        prev_cfg = 1;
      end else begin
        prev_cfg = 0;
      end
      if (host_req) begin
        check("req_single_cycle", prev_req, 0);
        check("req_after_init", init_done, 1);
        check("req_miim_sel", host_miim_sel, 1);
      end
      prev_req = host_req;
      if (cmp_valid) begin
        check("irq_with_cmp", send_irq, 1);
        if (cmp_exp.size() == 0) check("cmp_unexpected", cmp_data, 64'h0);
        else check("cmp_data", cmp_data, cmp_exp.pop_front());
        n_cmp++;
      end else if (send_irq) begin
        check("irq_without_cmp", send_irq, 0);
      end
    end
  end

  task automatic push(input logic [31:0] d);
    acc_data = d;
    acc_en   = 1'b1;
    @(posedge host_clk);
    #1;
    acc_en = 1'b0;
  endtask

  task automatic push_cfg_exp();
    cfg_exp.push_back({10'h240, 32'h1C00_0000});
    cfg_exp.push_back({10'h280, 32'h1100_0000});
    cfg_exp.push_back({10'h340, 32'h0000_0029});
  endtask

  task automatic wait_cmp(input int target, input int budget, input string name);
    int k = 0;
    while (n_cmp < target && k < budget) begin
      @(negedge host_clk);
      k++;
    end
    check(name, (n_cmp >= target), 1);
  endtask

  task automatic wait_init(input int budget, input string name);
    int k = 0;
    while (init_done !== 1'b1 && k < budget) begin
      @(negedge host_clk);
      k++;
    end
    check(name, init_done, 1);
  endtask

  task automatic wait_req(input int budget, input string name);
    int k = 0;
    while (host_req !== 1'b1 && k < budget) begin
      @(negedge host_clk);
      k++;
    end
    check(name, host_req, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    host_reset = 1'b1;
    mac_rst    = 1'b0;
    acc_en     = 1'b0;
    acc_data   = '0;

    // Reset values
    repeat (3) @(posedge host_clk);
    @(negedge host_clk);
    check("rst_opcode", host_opcode, 2'b11);
    check("rst_addr", host_addr, 0);
    check("rst_wr_data", host_wr_data, 0);
    check("rst_miim_sel", host_miim_sel, 0);
    check("rst_req", host_req, 0);
    check("rst_cmp_valid", cmp_valid, 0);
    check("rst_cmp_data", cmp_data, 0);
    check("rst_send_irq", send_irq, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_fifo_full", fifo_full, 0);

    // Initial configuration sequence
    push_cfg_exp();
    @(posedge host_clk);
    #1 host_reset = 1'b0;
    wait_init(100, "init_done_1");
    check("cfg_all_written_1", cfg_exp.size(), 0);
    check("idle_miim_sel", host_miim_sel, 1);

    // Read command: push->req latency and read-data return
    base = n_cmp;
    cmp_exp.push_back(32'h0C05_1234);
    push(32'h0C05_0000);
    @(negedge host_clk); check("req_lat_t0", host_req, 0);
    @(negedge host_clk); check("req_lat_t1", host_req, 0);
    @(negedge host_clk); check("req_lat_t2", host_req, 1);
    check("req_addr", host_addr, 10'h005);
    check("req_opcode", host_opcode, 2'b11);
    @(negedge host_clk); check("req_lat_t3", host_req, 0);
    wait_cmp(base + 1, 50, "cmp_read_done");

    // Write (upper nibble ignored) and op 10 read
    base = n_cmp;
    cmp_exp.push_back(32'h0423_ABCD);
    cmp_exp.push_back(32'h0811_1240);
    push(32'hF423_ABCD);
    push(32'h0811_5555);
    wait_cmp(base + 2, 80, "cmp_wr_rd_done");

    // Queue filling during re-init: overflow, saturation, in-order drain
    @(negedge host_clk);
    mac_rst = 1'b1;
    repeat (4) @(negedge host_clk);
    check("init_drop_on_mac", init_done, 0);
    @(posedge host_clk); #1;
    cmp_exp.push_back(32'h0401_1111);
    cmp_exp.push_back(32'h0C02_1231);
    cmp_exp.push_back(32'h0003_2222);
    cmp_exp.push_back(32'h0804_1233);
    push(32'h0401_1111);
    push(32'h0C02_0000);
    push(32'h0003_2222);
    push(32'h0804_0000);
    push(32'h0405_5555);
    @(negedge host_clk);
    check("fifo_full", fifo_full, 1);
    check("ovf_one", ovf_cnt, 1);
    acc_data = 32'h0406_6666;
    acc_en   = 1'b1;
    repeat (300) @(posedge host_clk);
    #1 acc_en = 1'b0;
    @(negedge host_clk);
    check("ovf_saturate", ovf_cnt, 255);
    check("fifo_still_full", fifo_full, 1);
    base = n_cmp;
    push_cfg_exp();
    mac_rst = 1'b0;
    wait_init(100, "init_done_2");
    check("cfg_all_written_2", cfg_exp.size(), 0);
    wait_cmp(base + 4, 200, "cmp_four_in_order");
    check("fifo_drained", fifo_full, 0);

    // Ready timeout, then the next command proceeds
    base = n_cmp;
    hang = 1;
    cmp_exp.push_back(32'h8477_0000);
    cmp_exp.push_back(32'h0C09_1238);
    push(32'h0477_0001);
    push(32'h0C09_0000);
    wait_req(20, "tmo_req_seen");
    k = 0;
    while (n_cmp < base + 1 && k < 100) begin
      @(negedge host_clk);
      k++;
    end
    check("tmo_completed", (n_cmp >= base + 1), 1);
    check("tmo_latency", (k >= TB_TMO - 1 && k <= TB_TMO + 3), 1);
    hang = 0;
    wait_cmp(base + 2, 60, "cmp_after_tmo");

    // MAC reset during WAIT_RDY with two queued: no completion, flush, re-init
    base = n_cmp;
    hang = 1;
    push(32'h0410_0000);
    push(32'h0411_0000);
    push(32'h0412_0000);
    wait_req(20, "abort_req_seen");
    repeat (2) @(negedge host_clk);
    mac_rst = 1'b1;
    repeat (4) @(negedge host_clk);
    check("abort_init_low", init_done, 0);
    check("abort_req_low", host_req, 0);
    check("abort_no_full", fifo_full, 0);
    push_cfg_exp();
    mac_rst = 1'b0;
    hang    = 0;
    wait_init(100, "init_done_3");
    repeat (30) @(negedge host_clk);
    check("abort_no_cmp", n_cmp, base);
    cmp_exp.push_back(32'h0FFF_162E);
    push(32'h0FFF_0000);
    wait_cmp(base + 1, 60, "cmp_after_reinit");

    repeat (5) @(negedge host_clk);
    check("cmp_queue_empty", cmp_exp.size(), 0);
    check("cfg_queue_empty", cfg_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
